// File: rtl/riscv_multicycle_control_if.sv
// Control/status bundle between the multicycle control FSM (master) and the datapath (slave).
interface riscv_multicycle_control_if #(
  parameter int unsigned OPCODE_W = 7,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned CNT_W    = 32
) ();
  logic                run_i;
  logic [OPCODE_W-1:0] inst_opcode_i;
  logic                mem_ready_i;
  logic                pc_write_o;
  logic                ir_write_o;
  logic                alu_src_o;
  logic                mem_to_reg_o;
  logic                reg_write_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                branch_o;
  logic [ALUOP_W-1:0]  alu_op_o;
  logic                illegal_o;
  logic                fault_o;
  logic [CNT_W-1:0]    retired_o;

  modport master (
    input  run_i, inst_opcode_i, mem_ready_i,
    output pc_write_o, ir_write_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o,
           mem_write_o, branch_o, alu_op_o, illegal_o, fault_o, retired_o
  );

  modport slave (
    output run_i, inst_opcode_i, mem_ready_i,
    input  pc_write_o, ir_write_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o,
           mem_write_o, branch_o, alu_op_o, illegal_o, fault_o, retired_o
  );
endinterface

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I main control FSM with memory-ready wait timeout, trap state and retire counter.
// Define RISCV_MC_JUMP_EN to accept jal/jalr through an extra one-cycle JUMP state.
module riscv_multicycle_control #(
  parameter int unsigned OPCODE_W = 7,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 32
) (
  input logic                        clk_i,
  input logic                        rst_n_i,
  riscv_multicycle_control_if.master bus
);
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StTrap   = 3'd6;
`ifdef RISCV_MC_JUMP_EN
  localparam logic [2:0] StJump   = 3'd7;
`endif

  localparam logic [2:0] ClsR     = 3'd0;
  localparam logic [2:0] ClsI     = 3'd1;
  localparam logic [2:0] ClsLoad  = 3'd2;
  localparam logic [2:0] ClsStore = 3'd3;
  localparam logic [2:0] ClsBr    = 3'd4;
  localparam logic [2:0] ClsJal   = 3'd5;
  localparam logic [2:0] ClsJalr  = 3'd6;
  localparam logic [2:0] ClsBad   = 3'd7;

  // Last wait cycle index; a ready seen in this cycle still counts as success.
  localparam logic [15:0] WaitLimit = 16'(TIMEOUT - 1);

  function automatic logic [2:0] decode_class(input logic [OPCODE_W-1:0] op);
    logic [2:0] cls;
    cls = ClsBad;
    if      (op == OPCODE_W'(7'b0110011)) cls = ClsR;
    else if (op == OPCODE_W'(7'b0010011)) cls = ClsI;
    else if (op == OPCODE_W'(7'b0000011)) cls = ClsLoad;
    else if (op == OPCODE_W'(7'b0100011)) cls = ClsStore;
    else if (op == OPCODE_W'(7'b1100011)) cls = ClsBr;
    else if (op == OPCODE_W'(7'b1101111)) cls = ClsJal;
    else if (op == OPCODE_W'(7'b1100111)) cls = ClsJalr;
    return cls;
  endfunction

  logic [2:0]          r_state_q, r_state_d;
  logic [OPCODE_W-1:0] r_opcode_q, r_opcode_d;
  logic [15:0]         r_wait_q, r_wait_d;
  logic [CNT_W-1:0]    r_retired_q, r_retired_d;
  logic                r_illegal_q, r_illegal_d;
  logic                r_fault_q, r_fault_d;

  logic [2:0] w_cls;
  logic [2:0] w_dec_cls;
  logic       w_retire;
  logic [1:0] w_alu_op;

  assign w_cls     = decode_class(r_opcode_q);
  assign w_dec_cls = decode_class(bus.inst_opcode_i);

  always_comb begin
    r_state_d   = r_state_q;
    r_opcode_d  = r_opcode_q;
    r_wait_d    = r_wait_q;
    r_retired_d = r_retired_q;
    r_illegal_d = r_illegal_q;
    r_fault_d   = r_fault_q;
    w_retire    = 1'b0;
    unique case (r_state_q)
      StIdle: if (bus.run_i) r_state_d = StFetch;
      StFetch, StMem: begin
        if (bus.mem_ready_i) begin
          if (r_state_q == StFetch)  r_state_d = StDecode;
          else if (w_cls == ClsLoad) r_state_d = StWb;
          else                       w_retire  = 1'b1;
        end else if (r_wait_q == WaitLimit) begin
          r_state_d = StTrap;
          r_fault_d = 1'b1;
        end
      end
      StDecode: begin
        r_opcode_d = bus.inst_opcode_i;
        unique case (w_dec_cls)
          ClsR, ClsI, ClsLoad, ClsStore, ClsBr: r_state_d = StExec;
`ifdef RISCV_MC_JUMP_EN
          ClsJal, ClsJalr: r_state_d = StJump;
`endif
          default: begin
            r_state_d   = StTrap;
            r_illegal_d = 1'b1;
          end
        endcase
      end
      StExec: begin
        unique case (w_cls)
          ClsBr:             w_retire  = 1'b1;
          ClsR, ClsI:        r_state_d = StWb;
          ClsLoad, ClsStore: r_state_d = StMem;
          default:           r_state_d = StTrap;
        endcase
      end
      StWb: w_retire = 1'b1;
`ifdef RISCV_MC_JUMP_EN
      StJump: w_retire = 1'b1;
`endif
      StTrap: r_state_d = StTrap;
      default: r_state_d = StIdle;
    endcase
    if (w_retire) begin
      r_retired_d = r_retired_q + CNT_W'(1);
      r_state_d   = bus.run_i ? StFetch : StIdle;
    end
    // Any state change restarts the wait count; staying in FETCH/MEM means still waiting.
    if (r_state_d != r_state_q) begin
      r_wait_d = '0;
    end else if (r_state_q == StFetch || r_state_q == StMem) begin
      r_wait_d = r_wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state_q   <= StIdle;
      r_opcode_q  <= '0;
      r_wait_q    <= '0;
      r_retired_q <= '0;
      r_illegal_q <= 1'b0;
      r_fault_q   <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      r_opcode_q  <= r_opcode_d;
      r_wait_q    <= r_wait_d;
      r_retired_q <= r_retired_d;
      r_illegal_q <= r_illegal_d;
      r_fault_q   <= r_fault_d;
    end
  end

  always_comb begin
    bus.pc_write_o   = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.alu_src_o    = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.branch_o     = 1'b0;
    w_alu_op         = 2'b00;
    unique case (r_state_q)
      StFetch: begin
        bus.mem_read_o = 1'b1;
        bus.ir_write_o = bus.mem_ready_i;
        bus.pc_write_o = bus.mem_ready_i;
      end
      StExec: begin
        unique case (w_cls)
          ClsI:              w_alu_op = 2'b01;
          ClsBr:             w_alu_op = 2'b10;
          ClsLoad, ClsStore: w_alu_op = 2'b11;
          default:           w_alu_op = 2'b00;
        endcase
        bus.alu_src_o = (w_cls == ClsI) || (w_cls == ClsLoad) || (w_cls == ClsStore);
        bus.branch_o  = (w_cls == ClsBr);
      end
      StMem: begin
        bus.mem_read_o  = (w_cls == ClsLoad);
        bus.mem_write_o = (w_cls == ClsStore);
      end
      StWb: begin
        bus.reg_write_o  = 1'b1;
        bus.mem_to_reg_o = (w_cls == ClsLoad);
      end
`ifdef RISCV_MC_JUMP_EN
      StJump: begin
        bus.reg_write_o = 1'b1;
        bus.pc_write_o  = 1'b1;
        bus.alu_src_o   = (w_cls == ClsJalr);
      end
`endif
      default: ;
    endcase
  end

  assign bus.alu_op_o  = ALUOP_W'(w_alu_op);
  assign bus.illegal_o = r_illegal_q;
  assign bus.fault_o   = r_fault_q;
  assign bus.retired_o = r_retired_q;
endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Directed bench: dut_a uses default parameters, dut_b uses TIMEOUT=4 and CNT_W=3.
module tb_riscv_multicycle_control;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLd   = 7'b0000011;
  localparam logic [6:0] OpSt   = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpBad  = 7'b1111111;

  // {pc_write, ir_write, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
  //  alu_op[1:0], illegal, fault}
  localparam logic [11:0] ExpIdle      = 12'b0000_0000_0000;
  localparam logic [11:0] ExpFetchRdy  = 12'b1100_0100_0000;
  localparam logic [11:0] ExpFetchWait = 12'b0000_0100_0000;
  localparam logic [11:0] ExpExecR     = 12'b0000_0000_0000;
  localparam logic [11:0] ExpExecI     = 12'b0010_0000_0100;
  localparam logic [11:0] ExpExecLs    = 12'b0010_0000_1100;
  localparam logic [11:0] ExpExecB     = 12'b0000_0001_1000;
  localparam logic [11:0] ExpMemLd     = 12'b0000_0100_0000;
  localparam logic [11:0] ExpMemSt     = 12'b0000_0010_0000;
  localparam logic [11:0] ExpWbR       = 12'b0000_1000_0000;
  localparam logic [11:0] ExpWbLd      = 12'b0001_1000_0000;
  localparam logic [11:0] ExpTrapIll   = 12'b0000_0000_0010;
  localparam logic [11:0] ExpTrapFlt   = 12'b0000_0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_ret_a = 0;

  always #5 clk = ~clk;

  riscv_multicycle_control_if #(.OPCODE_W(7), .ALUOP_W(2), .CNT_W(32)) ia ();
  riscv_multicycle_control_if #(.OPCODE_W(7), .ALUOP_W(2), .CNT_W(3))  ib ();

  riscv_multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .TIMEOUT(255), .CNT_W(32)) dut_a (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ia)
  );

  riscv_multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ib)
  );

  logic [11:0] st_a, st_b;
  assign st_a = {ia.pc_write_o, ia.ir_write_o, ia.alu_src_o, ia.mem_to_reg_o, ia.reg_write_o,
                 ia.mem_read_o, ia.mem_write_o, ia.branch_o, ia.alu_op_o, ia.illegal_o,
                 ia.fault_o};
  assign st_b = {ib.pc_write_o, ib.ir_write_o, ib.alu_src_o, ib.mem_to_reg_o, ib.reg_write_o,
                 ib.mem_read_o, ib.mem_write_o, ib.branch_o, ib.alu_op_o, ib.illegal_o,
                 ib.fault_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ia.run_i = 1'b0; ia.mem_ready_i = 1'b0; ia.inst_opcode_i = '0;
    ib.run_i = 1'b0; ib.mem_ready_i = 1'b0; ib.inst_opcode_i = '0;
    exp_ret_a = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ia.run_i = 1'b0; ia.mem_ready_i = 1'b0; ia.inst_opcode_i = '0;
    ib.run_i = 1'b0; ib.mem_ready_i = 1'b0; ib.inst_opcode_i = '0;
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (st_a !== ExpIdle) begin
      n_fail++; $display("FAIL reset_strobes_a got=%b exp=%b", st_a, ExpIdle); end
    n_checks++; if (ia.retired_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_retired_a got=%0d exp=0", ia.retired_o); end
    n_checks++; if (st_b !== ExpIdle || ib.retired_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_b got=%b/%0d exp=%b/0", st_b, ib.retired_o, ExpIdle); end
    do_reset();
  endtask

  task automatic test_r_type();
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpR; #1;
    n_checks++; if (st_a !== ExpIdle) begin
      n_fail++; $display("FAIL r_idle got=%b exp=%b", st_a, ExpIdle); end
    step();
    n_checks++; if (st_a !== ExpFetchRdy) begin
      n_fail++; $display("FAIL r_fetch got=%b exp=%b", st_a, ExpFetchRdy); end
    step();
    n_checks++; if (st_a !== ExpIdle) begin
      n_fail++; $display("FAIL r_decode got=%b exp=%b", st_a, ExpIdle); end
    step();
    n_checks++; if (st_a !== ExpExecR) begin
      n_fail++; $display("FAIL r_exec got=%b exp=%b", st_a, ExpExecR); end
    step(); ia.run_i = 1'b0; #1;
    n_checks++; if (st_a !== ExpWbR || ia.retired_o !== 32'd0) begin
      n_fail++; $display("FAIL r_wb got=%b/%0d exp=%b/0", st_a, ia.retired_o, ExpWbR); end
    step(); exp_ret_a++;
    n_checks++; if (st_a !== ExpIdle || ia.retired_o !== 32'(exp_ret_a)) begin
      n_fail++; $display("FAIL r_retire got=%b/%0d exp=%b/%0d", st_a, ia.retired_o, ExpIdle,
                         exp_ret_a); end
  endtask

  task automatic test_i_type();
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpI;
    step(); step(); step();
    n_checks++; if (st_a !== ExpExecI) begin
      n_fail++; $display("FAIL i_exec got=%b exp=%b", st_a, ExpExecI); end
    step(); ia.run_i = 1'b0; #1;
    n_checks++; if (st_a !== ExpWbR) begin
      n_fail++; $display("FAIL i_wb got=%b exp=%b", st_a, ExpWbR); end
    step(); exp_ret_a++;
    n_checks++; if (ia.retired_o !== 32'(exp_ret_a)) begin
      n_fail++; $display("FAIL i_retire got=%0d exp=%0d", ia.retired_o, exp_ret_a); end
  endtask

  task automatic test_load_wait();
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpLd;
    step(); step(); step();
    n_checks++; if (st_a !== ExpExecLs) begin
      n_fail++; $display("FAIL ld_exec got=%b exp=%b", st_a, ExpExecLs); end
    ia.mem_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) begin ia.mem_ready_i = 1'b1; #1; end
      n_checks++; if (st_a !== ExpMemLd) begin
        n_fail++; $display("FAIL ld_mem%0d got=%b exp=%b", i, st_a, ExpMemLd); end
    end
    step(); ia.run_i = 1'b0; #1;
    n_checks++; if (st_a !== ExpWbLd || ia.retired_o !== 32'(exp_ret_a)) begin
      n_fail++; $display("FAIL ld_wb got=%b/%0d exp=%b/%0d", st_a, ia.retired_o, ExpWbLd,
                         exp_ret_a); end
    step(); exp_ret_a++;
    n_checks++; if (ia.retired_o !== 32'(exp_ret_a)) begin
      n_fail++; $display("FAIL ld_retire got=%0d exp=%0d", ia.retired_o, exp_ret_a); end
  endtask

  task automatic test_store_branch();
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpSt;
    step(); step(); step();
    n_checks++; if (st_a !== ExpExecLs) begin
      n_fail++; $display("FAIL st_exec got=%b exp=%b", st_a, ExpExecLs); end
    step(); ia.inst_opcode_i = OpB; #1;
    n_checks++; if (st_a !== ExpMemSt) begin
      n_fail++; $display("FAIL st_mem got=%b exp=%b", st_a, ExpMemSt); end
    step(); exp_ret_a++;
    n_checks++; if (st_a !== ExpFetchRdy || ia.retired_o !== 32'(exp_ret_a)) begin
      n_fail++; $display("FAIL st_retire got=%b/%0d exp=%b/%0d", st_a, ia.retired_o,
                         ExpFetchRdy, exp_ret_a); end
    step();
    n_checks++; if (st_a !== ExpIdle) begin
      n_fail++; $display("FAIL b_decode got=%b exp=%b", st_a, ExpIdle); end
    step(); ia.run_i = 1'b0; #1;
    n_checks++; if (st_a !== ExpExecB) begin
      n_fail++; $display("FAIL b_exec got=%b exp=%b", st_a, ExpExecB); end
    step(); exp_ret_a++;
    n_checks++; if (st_a !== ExpIdle || ia.retired_o !== 32'(exp_ret_a)) begin
      n_fail++; $display("FAIL b_retire got=%b/%0d exp=%b/%0d", st_a, ia.retired_o, ExpIdle,
                         exp_ret_a); end
  endtask

  task automatic test_async_reset();
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpLd;
    step(); step(); step();
    ia.mem_ready_i = 1'b0;
    step();
    n_checks++; if (st_a !== ExpMemLd) begin
      n_fail++; $display("FAIL ar_mem got=%b exp=%b", st_a, ExpMemLd); end
    rst_n = 1'b0; #1;
    n_checks++; if (st_a !== ExpIdle || ia.retired_o !== 32'd0) begin
      n_fail++; $display("FAIL ar_clear got=%b/%0d exp=%b/0", st_a, ia.retired_o, ExpIdle); end
    do_reset();
  endtask

  task automatic test_illegal();
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpBad;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++; if (st_a !== ExpTrapIll) begin
        n_fail++; $display("FAIL ill_trap%0d got=%b exp=%b", i, st_a, ExpTrapIll); end
    end
    do_reset(); #1;
    n_checks++; if (st_a !== ExpIdle) begin
      n_fail++; $display("FAIL ill_clear got=%b exp=%b", st_a, ExpIdle); end
  endtask

  task automatic test_jump();
`ifdef RISCV_MC_JUMP_EN
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpJal;
    step(); step(); step(); ia.run_i = 1'b0; #1;
    n_checks++; if (st_a !== 12'b1000_1000_0000) begin
      n_fail++; $display("FAIL jal_jump got=%b exp=100010000000", st_a); end
    step();
    n_checks++; if (ia.retired_o !== 32'd1) begin
      n_fail++; $display("FAIL jal_retire got=%0d exp=1", ia.retired_o); end
    ia.run_i = 1'b1; ia.inst_opcode_i = OpJalr;
    step(); step(); step(); ia.run_i = 1'b0; #1;
    n_checks++; if (st_a !== 12'b1010_1000_0000) begin
      n_fail++; $display("FAIL jalr_jump got=%b exp=101010000000", st_a); end
    do_reset();
`else
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpJal;
    step(); step(); step();
    n_checks++; if (st_a !== ExpTrapIll) begin
      n_fail++; $display("FAIL jal_illegal got=%b exp=%b", st_a, ExpTrapIll); end
    do_reset();
    ia.run_i = 1'b1; ia.mem_ready_i = 1'b1; ia.inst_opcode_i = OpJalr;
    step(); step(); step();
    n_checks++; if (st_a !== ExpTrapIll) begin
      n_fail++; $display("FAIL jalr_illegal got=%b exp=%b", st_a, ExpTrapIll); end
    do_reset();
`endif
  endtask

  task automatic test_timeout();
    ib.run_i = 1'b1; ib.mem_ready_i = 1'b0; ib.inst_opcode_i = OpB;
    step();
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (st_b !== ExpFetchWait) begin
        n_fail++; $display("FAIL to_wait%0d got=%b exp=%b", i, st_b, ExpFetchWait); end
      step();
    end
    n_checks++; if (st_b !== ExpTrapFlt) begin
      n_fail++; $display("FAIL to_fault got=%b exp=%b", st_b, ExpTrapFlt); end
    ib.mem_ready_i = 1'b1;
    repeat (3) step();
    n_checks++; if (st_b !== ExpTrapFlt) begin
      n_fail++; $display("FAIL to_hold got=%b exp=%b", st_b, ExpTrapFlt); end
    do_reset();
    ib.run_i = 1'b1; ib.mem_ready_i = 1'b0; ib.inst_opcode_i = OpB;
    step();
    for (int i = 1; i <= 3; i++) begin
      n_checks++; if (st_b !== ExpFetchWait) begin
        n_fail++; $display("FAIL lim_wait%0d got=%b exp=%b", i, st_b, ExpFetchWait); end
      step();
    end
    ib.mem_ready_i = 1'b1; #1;
    n_checks++; if (st_b !== ExpFetchRdy) begin
      n_fail++; $display("FAIL lim_ready got=%b exp=%b", st_b, ExpFetchRdy); end
    step();
    n_checks++; if (st_b !== ExpIdle) begin
      n_fail++; $display("FAIL lim_nofault got=%b exp=%b", st_b, ExpIdle); end
    step(); ib.run_i = 1'b0; #1;
    n_checks++; if (st_b !== ExpExecB) begin
      n_fail++; $display("FAIL lim_exec got=%b exp=%b", st_b, ExpExecB); end
    step();
    n_checks++; if (st_b !== ExpIdle || ib.retired_o !== 3'd1) begin
      n_fail++; $display("FAIL lim_retire got=%b/%0d exp=%b/1", st_b, ib.retired_o, ExpIdle); end
    do_reset();
  endtask

  task automatic test_wrap();
    logic [2:0] exp_cnt;
    ib.run_i = 1'b1; ib.mem_ready_i = 1'b1; ib.inst_opcode_i = OpB;
    exp_cnt = 3'd0;
    step();
    for (int i = 1; i <= 9; i++) begin
      repeat (3) step();
      exp_cnt = exp_cnt + 3'd1;
      n_checks++; if (ib.retired_o !== exp_cnt) begin
        n_fail++; $display("FAIL wrap%0d got=%0d exp=%0d", i, ib.retired_o, exp_cnt); end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_load_wait();
    test_store_branch();
    test_async_reset();
    test_illegal();
    test_jump();
    test_timeout();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
